ahb_arbiter: RTL and testbench
==============================

# ahb_arbiter

Round-robin AHB bus arbiter that shares a single AHB slave port (the AHP slave and its memory) between up to four bus masters. Samples per-master bus requests and lock requests and drives one-hot grants, and the registered HMASTER select for the address/control/write-data multiplexer. Honours fixed-length bursts (never re-arbitrates mid-burst), locked transfers and wait states. Sits between the master ports and the shared address/data mux in front of the slave.

## Interface
- NUM_MASTERS, 4, number of requesters (2..4); HMASTER width fixed at 2
- DEFAULT_MASTER, 0, master parked on the bus when nobody requests
- HCLK  in  1  bus clock, all state on rising edge
- HRESET  in  1  asynchronous, active-high reset
- HBUSREQ  in  NUM_MASTERS  per-master bus request
- HLOCK  in  NUM_MASTERS  per-master locked-access request
- HREADY  in  1  shared transfer-done from the slave; 1 = current address phase accepted
- HTRANS  in  2  muxed transfer type of current bus owner (IDLE=0, BUSY=1, NON_SEQ=2, SEQ=3)
- HBURST  in  3  muxed burst type (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7)
- HGRANT  out  NUM_MASTERS  one-hot grant, registered
- HMASTER  out  2  index of master owning the address phase, registered
- HMASTLOCK  out  1  current address phase is locked, registered

## Operation
- Reset values: HGRANT = one-hot DEFAULT_MASTER, HMASTER = DEFAULT_MASTER, HMASTLOCK = 0, beat counter = 0, state = PARK.
- States: PARK (default master granted, no request from it), OWN (granted master owns bus, no fixed burst in flight), BURST (fixed-length burst in flight, counter > 0).
- Beat counter, 5 bits, counts address phases still to be issued. Burst length L: SINGLE/INCR = 1, WRAP4/INCR4 = 4, WRAP8/INCR8 = 8, WRAP16/INCR16 = 16.
  - Accepted NON_SEQ (HREADY=1): counter <= L-1; L>1 -> BURST.
  - Accepted SEQ in BURST: counter <= counter-1; reaching 0 -> OWN.
  - BUSY: counter holds.
  - IDLE in BURST (early termination): counter <= 0, -> OWN.
- Arbitration point = rising edge with HREADY=1 and any of: state PARK; state OWN and (owner HBUSREQ=0 or HTRANS=IDLE or accepted NON_SEQ with L=1); state BURST and last address phase accepted (SEQ with counter=1, or early-termination IDLE).
- INCR (undefined length) treated as L=1 per beat; re-arbitration only when owner drops HBUSREQ.
- At arbitration point: if owner HLOCK=1, grant held. Else round-robin search starting at owner+1 modulo NUM_MASTERS over HBUSREQ; first hit granted. No requester -> DEFAULT_MASTER (-> PARK).
- Owner with HBUSREQ still high and no other requester is re-granted (no gap).
- Outside arbitration points HGRANT is frozen.
- Indexes >= NUM_MASTERS never granted; their inputs ignored.

## Timing
- HGRANT updates on the edge of the arbitration point (during owner's final address phase).
- HMASTER and HMASTLOCK update on the next rising edge with HREADY=1 after HGRANT changed (handover = 1 accepted cycle latency). HMASTLOCK <= HLOCK[granted index] sampled at that edge.
- HREADY=0: HGRANT, HMASTER, HMASTLOCK, counter and state all hold; pending handover waits.
- Simultaneous request from all masters with owner releasing: grants rotate one per arbitration point, no master waits more than NUM_MASTERS-1 arbitration points.
- HRESET asserted mid-burst: outputs return to reset values immediately (asynchronous), counter cleared; first arbitration after release on first HREADY=1 edge.

## Test plan
- Reset: HRESET=1 with random inputs -> HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0; release, no requests -> stays parked on master 0.
- Round-robin: HBUSREQ=4'b1111, owner issues SINGLE NON_SEQ each cycle, HREADY=1 -> HGRANT sequence 0010,0100,1000,0001; HMASTER lags HGRANT by one cycle: 0,1,2,3.
- Burst hold: master 1 granted issues INCR4 (NON_SEQ+3 SEQ), master 2 requesting -> HGRANT stays 0010 for 3 cycles, switches to 0100 on edge accepting 4th beat, HMASTER=2 one cycle later.
- Wait states: same INCR4 with HREADY=0 for 2 cycles on beat 2 -> counter and grant hold; switch delayed exactly 2 cycles.
- Lock: master 3 HLOCK=1, HBUSREQ=1, others requesting -> grant held on 3 across SINGLE transfers, HMASTLOCK=1; HLOCK drops -> next arbitration grants master 0.
- Early termination and async reset: WRAP8 interrupted by IDLE after beat 3 -> rearbitrates that edge; HRESET pulsed mid-WRAP16 -> outputs to reset values same cycle, counter=0.

Source files
------------

// File: rtl/ahb_arbiter_if.sv
// Bus-side signals shared between the AHB masters/slave and the round-robin arbiter.
// The arbiter connects through the slave modport; the requesters/slave model use master.
interface ahb_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    logic [NUM_MASTERS-1:0] HBUSREQ;
    logic [NUM_MASTERS-1:0] HLOCK;
    logic                   HREADY;
    logic [1:0]             HTRANS;
    logic [2:0]             HBURST;
    logic [NUM_MASTERS-1:0] HGRANT;
    logic [1:0]             HMASTER;
    logic                   HMASTLOCK;

    modport master (
        output HBUSREQ, HLOCK, HREADY, HTRANS, HBURST,
        input  HGRANT, HMASTER, HMASTLOCK
    );

    modport slave (
        input  HBUSREQ, HLOCK, HREADY, HTRANS, HBURST,
        output HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter: grants one of up to four masters and never re-arbitrates
// inside a fixed-length burst; HMASTER/HMASTLOCK follow the grant one accepted cycle later.
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input logic         HCLK,
    input logic         HRESET,
    ahb_arbiter_if.slave bus
);
    localparam logic [1:0] PARK  = 2'd0;
    localparam logic [1:0] OWN   = 2'd1;
    localparam logic [1:0] BURST = 2'd2;

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    localparam logic [1:0]             DEF_IDX  = 2'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT1 = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    logic [1:0]             state_q, state_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [1:0]             grantIdx_q, grantIdx_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [1:0]             master_q;
    logic                   mastLock_q;

    logic [4:0] burstLen;
    logic       nonSeqAcc, startBurst, arbPoint;
    logic       ownerReq, ownerLock, winnerFound;
    logic [1:0] winnerIdx;
    logic [2:0] candSum;
    logic [1:0] cand;

    always_comb begin
        burstLen = 5'd16;
        case (bus.HBURST)
            3'd0, 3'd1: burstLen = 5'd1;
            3'd2, 3'd3: burstLen = 5'd4;
            3'd4, 3'd5: burstLen = 5'd8;
            default:    burstLen = 5'd16;
        endcase
    end

    assign ownerReq   = bus.HBUSREQ[grantIdx_q];
    assign ownerLock  = bus.HLOCK[grantIdx_q];
    assign nonSeqAcc  = bus.HREADY && (bus.HTRANS == TR_NONSEQ);
    assign startBurst = nonSeqAcc && (burstLen != 5'd1);

    // Walk from owner+N down to owner+1 so the nearest requester after the owner wins last.
    always_comb begin
        winnerFound = 1'b0;
        winnerIdx   = DEF_IDX;
        candSum     = '0;
        cand        = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            candSum = {1'b0, grantIdx_q} + 3'(i);
            if (candSum >= 3'(NUM_MASTERS)) candSum = candSum - 3'(NUM_MASTERS);
            cand = candSum[1:0];
            if (bus.HBUSREQ[cand]) begin
                winnerFound = 1'b1;
                winnerIdx   = cand;
            end
        end
    end

    always_comb begin
        arbPoint = 1'b0;
        case (state_q)
            PARK:    arbPoint = !startBurst;
            OWN:     arbPoint = !startBurst &&
                                (!ownerReq || (bus.HTRANS == TR_IDLE) || nonSeqAcc);
            BURST:   arbPoint = ((bus.HTRANS == TR_SEQ) && (cnt_q == 5'd1)) ||
                                (bus.HTRANS == TR_IDLE);
            default: arbPoint = 1'b1;
        endcase
        arbPoint = arbPoint && bus.HREADY;
    end

    always_comb begin
        cnt_d      = cnt_q;
        state_d    = state_q;
        grantIdx_d = grantIdx_q;
        if (bus.HREADY) begin
            if (bus.HTRANS == TR_NONSEQ) begin
                cnt_d = burstLen - 5'd1;
            end else if (state_q == BURST) begin
                if (bus.HTRANS == TR_SEQ)       cnt_d = cnt_q - 5'd1;
                else if (bus.HTRANS == TR_IDLE) cnt_d = 5'd0;
            end

            if (startBurst) begin
                state_d = BURST;
            end else if (arbPoint) begin
                state_d = (ownerLock || winnerFound) ? OWN : PARK;
            end else if ((state_q == BURST) && (cnt_d == 5'd0)) begin
                state_d = OWN;
            end

            if (arbPoint && !ownerLock) grantIdx_d = winnerFound ? winnerIdx : DEF_IDX;
        end
        grant_d = ONE_HOT1 << grantIdx_d;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= PARK;
            cnt_q      <= 5'd0;
            grantIdx_q <= DEF_IDX;
            grant_q    <= ONE_HOT1 << DEF_IDX;
            master_q   <= DEF_IDX;
            mastLock_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grantIdx_q <= grantIdx_d;
            grant_q    <= grant_d;
            if (bus.HREADY) begin
                master_q   <= grantIdx_q;
                mastLock_q <= bus.HLOCK[grantIdx_q];
            end
        end
    end

    assign bus.HGRANT    = grant_q;
    assign bus.HMASTER   = master_q;
    assign bus.HMASTLOCK = mastLock_q;
endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: round-robin, burst hold, wait states, lock,
// early burst termination and asynchronous reset, with hand-computed expectations.
module tb_ahb_arbiter;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;
    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] INCR4  = 3'd3;
    localparam logic [2:0] WRAP8  = 3'd4;
    localparam logic [2:0] WRAP16 = 3'd6;

    logic HCLK = 1'b0;
    logic HRESET;
    int   checks   = 0;
    int   failures = 0;

    ahb_arbiter_if #(.NUM_MASTERS(4)) bus ();

    ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] lock,
                                 input logic [1:0] trans, input logic [2:0] burst,
                                 input logic ready);
        bus.HBUSREQ = req;
        bus.HLOCK   = lock;
        bus.HTRANS  = trans;
        bus.HBURST  = burst;
        bus.HREADY  = ready;
        @(posedge HCLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expGrant,
                               input logic [1:0] expMaster, input logic expLock);
        checks++;
        assert (bus.HGRANT === expGrant) else begin
            failures++;
            $error("[TB] FAIL %s.grant: got %b expected %b", tag, bus.HGRANT, expGrant);
        end
        checks++;
        assert (bus.HMASTER === expMaster) else begin
            failures++;
            $error("[TB] FAIL %s.master: got %0d expected %0d", tag, bus.HMASTER, expMaster);
        end
        checks++;
        assert (bus.HMASTLOCK === expLock) else begin
            failures++;
            $error("[TB] FAIL %s.mastlock: got %b expected %b", tag, bus.HMASTLOCK, expLock);
        end
    endtask

    task automatic checkCount(input string tag, input logic [4:0] expCnt);
        checks++;
        assert (dut.cnt_q === expCnt) else begin
            failures++;
            $error("[TB] FAIL %s.count: got %0d expected %0d", tag, dut.cnt_q, expCnt);
        end
    endtask

    initial begin
        HRESET      = 1'b1;
        bus.HBUSREQ = 4'($urandom);
        bus.HLOCK   = 4'($urandom);
        bus.HTRANS  = 2'($urandom);
        bus.HBURST  = 3'($urandom);
        bus.HREADY  = 1'($urandom);
        repeat (2) @(posedge HCLK);
        #1;
        checkOutput("reset", 4'b0001, 2'd0, 1'b0);
        checkCount("reset", 5'd0);

        HRESET = 1'b0;
        applyStimulus(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
        checkOutput("park0", 4'b0001, 2'd0, 1'b0);
        applyStimulus(4'b0000, 4'b0000, IDLE, SINGLE, 1'b1);
        checkOutput("park1", 4'b0001, 2'd0, 1'b0);

        // All masters request, every owner issues SINGLE transfers.
        applyStimulus(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1);
        checkOutput("rr1", 4'b0010, 2'd0, 1'b0);
        applyStimulus(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1);
        checkOutput("rr2", 4'b0100, 2'd1, 1'b0);
        applyStimulus(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1);
        checkOutput("rr3", 4'b1000, 2'd2, 1'b0);
        applyStimulus(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1);
        checkOutput("rr4", 4'b0001, 2'd3, 1'b0);

        // INCR4 by master 1 while master 2 waits.
        applyStimulus(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
        checkOutput("bh.grant1", 4'b0010, 2'd0, 1'b0);
        applyStimulus(4'b0110, 4'b0000, NONSEQ, INCR4, 1'b1);
        checkOutput("bh.beat1", 4'b0010, 2'd1, 1'b0);
        checkCount("bh.beat1", 5'd3);
        applyStimulus(4'b0110, 4'b0000, SEQ, INCR4, 1'b1);
        checkOutput("bh.beat2", 4'b0010, 2'd1, 1'b0);
        applyStimulus(4'b0110, 4'b0000, SEQ, INCR4, 1'b1);
        checkOutput("bh.beat3", 4'b0010, 2'd1, 1'b0);
        checkCount("bh.beat3", 5'd1);
        applyStimulus(4'b0110, 4'b0000, SEQ, INCR4, 1'b1);
        checkOutput("bh.beat4", 4'b0100, 2'd1, 1'b0);
        checkCount("bh.beat4", 5'd0);
        applyStimulus(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1);
        checkOutput("bh.handover", 4'b0100, 2'd2, 1'b0);

        // Same INCR4 with two wait states on beat 2.
        applyStimulus(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
        checkOutput("ws.grant1", 4'b0010, 2'd2, 1'b0);
        applyStimulus(4'b0110, 4'b0000, NONSEQ, INCR4, 1'b1);
        checkOutput("ws.beat1", 4'b0010, 2'd1, 1'b0);
        applyStimulus(4'b0110, 4'b0000, SEQ, INCR4, 1'b0);
        checkOutput("ws.wait1", 4'b0010, 2'd1, 1'b0);
        checkCount("ws.wait1", 5'd3);
        applyStimulus(4'b0110, 4'b0000, SEQ, INCR4, 1'b0);
        checkOutput("ws.wait2", 4'b0010, 2'd1, 1'b0);
        checkCount("ws.wait2", 5'd3);
        applyStimulus(4'b0110, 4'b0000, SEQ, INCR4, 1'b1);
        checkCount("ws.beat2", 5'd2);
        applyStimulus(4'b0110, 4'b0000, SEQ, INCR4, 1'b1);
        checkOutput("ws.beat3", 4'b0010, 2'd1, 1'b0);
        applyStimulus(4'b0110, 4'b0000, SEQ, INCR4, 1'b1);
        checkOutput("ws.beat4", 4'b0100, 2'd1, 1'b0);
        applyStimulus(4'b0100, 4'b0000, IDLE, SINGLE, 1'b0);
        checkOutput("ws.pending", 4'b0100, 2'd1, 1'b0);
        applyStimulus(4'b0100, 4'b0000, IDLE, SINGLE, 1'b1);
        checkOutput("ws.handover", 4'b0100, 2'd2, 1'b0);

        // Master 3 locks the bus while everyone else requests.
        applyStimulus(4'b1111, 4'b1000, NONSEQ, SINGLE, 1'b1);
        checkOutput("lk.grant3", 4'b1000, 2'd2, 1'b0);
        applyStimulus(4'b1111, 4'b1000, NONSEQ, SINGLE, 1'b1);
        checkOutput("lk.hold1", 4'b1000, 2'd3, 1'b1);
        applyStimulus(4'b1111, 4'b1000, NONSEQ, SINGLE, 1'b1);
        checkOutput("lk.hold2", 4'b1000, 2'd3, 1'b1);
        applyStimulus(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1);
        checkOutput("lk.release", 4'b0001, 2'd3, 1'b0);

        // WRAP8 by master 0 cut short by IDLE after beat 3.
        applyStimulus(4'b0011, 4'b0000, NONSEQ, WRAP8, 1'b1);
        checkOutput("et.beat1", 4'b0001, 2'd0, 1'b0);
        checkCount("et.beat1", 5'd7);
        applyStimulus(4'b0011, 4'b0000, SEQ, WRAP8, 1'b1);
        applyStimulus(4'b0011, 4'b0000, SEQ, WRAP8, 1'b1);
        checkOutput("et.beat3", 4'b0001, 2'd0, 1'b0);
        checkCount("et.beat3", 5'd5);
        applyStimulus(4'b0011, 4'b0000, IDLE, WRAP8, 1'b1);
        checkOutput("et.idle", 4'b0010, 2'd0, 1'b0);
        checkCount("et.idle", 5'd0);

        // WRAP16 by master 1, then reset asserted between clock edges.
        applyStimulus(4'b0011, 4'b0000, NONSEQ, WRAP16, 1'b1);
        checkOutput("rst.beat1", 4'b0010, 2'd1, 1'b0);
        checkCount("rst.beat1", 5'd15);
        applyStimulus(4'b0011, 4'b0000, SEQ, WRAP16, 1'b1);
        checkCount("rst.beat2", 5'd14);
        #2 HRESET = 1'b1;
        #1;
        checkOutput("rst.async", 4'b0001, 2'd0, 1'b0);
        checkCount("rst.async", 5'd0);
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        applyStimulus(4'b0010, 4'b0000, IDLE, SINGLE, 1'b0);
        checkOutput("rst.wait", 4'b0001, 2'd0, 1'b0);
        applyStimulus(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
        checkOutput("rst.firstarb", 4'b0010, 2'd0, 1'b0);
        applyStimulus(4'b0010, 4'b0000, IDLE, SINGLE, 1'b1);
        checkOutput("rst.regrant", 4'b0010, 2'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
